glb_read_streamer: RTL and testbench
====================================

GLB_READ_STREAMER -- requirements
Module: glb_read_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, 32, GLB byte-address width.
REQ-002 Parameter LEN_WIDTH, 16, transfer byte-count width.
REQ-003 Parameter BUF_DEPTH, 2, output buffer entries; fixed at 2.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle command pulse; sampled only in IDLE.
REQ-007 base_addr  in  ADDR_WIDTH  first GLB byte address of the transfer.
REQ-008 byte_len  in  LEN_WIDTH  number of bytes to stream.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse at transfer completion.
REQ-011 glb_re  out  4  GLB read byte mask (0000, 0001, 0011, 0111, 1111).
REQ-012 glb_raddr  out  ADDR_WIDTH  GLB read byte address.
REQ-013 glb_dout  in  32  GLB read data, valid one cycle after glb_re != 0.
REQ-014 m_valid, m_ready  out/in  1  downstream handshake; a beat transfers when both are high.
REQ-015 m_data  out  32  beat data, byte 0 in bits [7:0].
REQ-016 m_keep  out  4  valid-byte mask of the beat (equals the glb_re of its read).
REQ-017 m_last  out  1  high on the final beat of the transfer.

Function
REQ-018 FSM states are IDLE, RUN and FLUSH.
REQ-019 IDLE -> RUN on start with byte_len>0: latch base_addr into the address counter and byte_len into the remaining counter.
REQ-020 IDLE with start and byte_len==0: no reads issued, busy stays 0, done pulses the next cycle.
REQ-021 In RUN, issue at most one read per cycle, only when (buffer occupancy + reads in flight) < 2.
REQ-022 Read mask: remaining>=4 -> 1111; remaining 3/2/1 -> 0111/0011/0001.
REQ-023 After each issue: address += 4 (modulo 2^ADDR_WIDTH wrap); remaining -= min(4, remaining).
REQ-024 The issue that brings remaining to 0 is tagged last; RUN -> FLUSH in the same edge.
REQ-025 glb_re = 0000 in every cycle without an issue; glb_raddr holds its last value.
REQ-026 Returned data is captured, with its mask and last tag, into the buffer tail exactly one cycle after issue.
REQ-027 Unused bytes (keep bit 0) in m_data are forwarded as received; consumers use m_keep.
REQ-028 m_valid = buffer not empty; m_data, m_keep and m_last come from the buffer head and stay stable while m_valid && !m_ready.
REQ-029 Simultaneous capture and pop in one cycle leaves occupancy unchanged; the buffer never overflows.
REQ-030 FLUSH -> IDLE when the last-tagged beat is accepted; done pulses in that same cycle; busy drops the next cycle.
REQ-031 start while busy is ignored with no side effects.
REQ-032 Throughput with m_ready held high: one beat per cycle after a 2-cycle initial latency (start -> first issue 1 cycle, issue -> m_valid 1 cycle).

Reset
REQ-033 rst forces IDLE, clears both buffer entries and the in-flight count, and drives busy=0, done=0, glb_re=0, glb_raddr=0, m_valid=0, m_keep=0, m_last=0 and m_data=0.
REQ-034 Reset mid-transfer abandons the transfer: no done pulse, and a read returning after reset is discarded.

Structure
REQ-035 The shared package holds the FSM state enum (IDLE/RUN/FLUSH), the read-mask constants and the GLB data width of 32.
REQ-036 The 2-entry output buffer is a sub-module, glb_stream_fifo, storing data, keep and last, with push/pop/full/empty.

Verification
REQ-037 base_addr=0x100, len=8, m_ready=1: re=1111 at 0x100 then 0x104; two beats, last on the 2nd; done coincides with the 2nd beat.
REQ-038 base_addr=0x200, len=6: second read has re=0011 at 0x204; second beat m_keep=0011 with m_last=1.
REQ-039 len=16, m_ready=0 for 10 cycles then 1: exactly 2 reads issued before the stall, no further re until a pop; all 4 beats in order with correct data.
REQ-040 len=0: no glb_re activity; done pulses 1 cycle after start; busy stays 0.
REQ-041 start pulse during RUN with different base_addr/len: ignored, the original transfer completes unchanged.
REQ-042 rst asserted after the 2nd beat of a len=16 transfer: outputs take reset values immediately; no done pulse; a new start then runs cleanly.

Source files
------------

// File: rtl/glb_read_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : glb_read_streamer_pkg
//  Purpose  : Shared types and constants for the GLB read streamer: FSM state
//             encoding, GLB read byte-mask constants, GLB data width and a
//             helper that maps the remaining byte count to a read mask.
//  Revision : 1.0  initial release
// ============================================================================
package glb_read_streamer_pkg;

    localparam int C_GLB_DATA_W = 32;
    localparam int C_GLB_KEEP_W = C_GLB_DATA_W / 8;

    localparam logic [C_GLB_KEEP_W-1:0] C_MASK_NONE = 4'b0000;
    localparam logic [C_GLB_KEEP_W-1:0] C_MASK_1B   = 4'b0001;
    localparam logic [C_GLB_KEEP_W-1:0] C_MASK_2B   = 4'b0011;
    localparam logic [C_GLB_KEEP_W-1:0] C_MASK_3B   = 4'b0111;
    localparam logic [C_GLB_KEEP_W-1:0] C_MASK_4B   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // A full word is read while at least 4 bytes remain; otherwise the low
    // two bits of the remaining count select a partial mask.
    function automatic logic [C_GLB_KEEP_W-1:0] read_mask(input logic i_ge4,
                                                          input logic [1:0] i_lo);
        logic [C_GLB_KEEP_W-1:0] w_m;
        if (i_ge4) begin
            w_m = C_MASK_4B;
        end else begin
            case (i_lo)
                2'd3:    w_m = C_MASK_3B;
                2'd2:    w_m = C_MASK_2B;
                2'd1:    w_m = C_MASK_1B;
                default: w_m = C_MASK_NONE;
            endcase
        end
        return w_m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/glb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : glb_stream_fifo
//  Purpose  : Two-entry output buffer holding {data, keep, last} beats.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             i_push, i_data, i_keep, i_last - write a beat at the tail
//             i_pop           - remove the head beat
//             o_data, o_keep, o_last - head beat
//             o_full, o_empty - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module glb_stream_fifo
    import glb_read_streamer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [C_GLB_DATA_W-1:0] i_data,
    input  logic [C_GLB_KEEP_W-1:0] i_keep,
    input  logic                    i_last,
    input  logic                    i_pop,
    output logic [C_GLB_DATA_W-1:0] o_data,
    output logic [C_GLB_KEEP_W-1:0] o_keep,
    output logic                    o_last,
    output logic                    o_full,
    output logic                    o_empty
);

    logic [C_GLB_DATA_W-1:0] r_data [0:1];
    logic [C_GLB_KEEP_W-1:0] r_keep [0:1];
    logic [1:0]              r_last;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_keep[0] <= '0;
            r_keep[1] <= '0;
            r_last    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_keep[r_wr_ptr] <= i_keep;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data = r_data[r_rd_ptr];
    assign o_keep = r_keep[r_rd_ptr];
    assign o_last = r_last[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/glb_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : glb_read_streamer
//  Purpose  : Streams byte_len bytes from the GLB, starting at base_addr, as
//             32-bit beats with a byte keep mask and a last flag.
//  Ports    : clk, rst                 - clock, asynchronous active-high reset
//             i_start, i_base_addr, i_byte_len - transfer command (IDLE only)
//             o_busy, o_done           - transfer status
//             o_glb_re, o_glb_raddr    - GLB read byte mask / byte address
//             i_glb_dout               - GLB read data, one cycle after read
//             o_m_valid, i_m_ready     - downstream handshake
//             o_m_data, o_m_keep, o_m_last - downstream beat
//  Revision : 1.0  initial release
// ============================================================================
module glb_read_streamer
    import glb_read_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [LEN_WIDTH-1:0]    i_byte_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [C_GLB_KEEP_W-1:0] o_glb_re,
    output logic [ADDR_WIDTH-1:0]   o_glb_raddr,
    input  logic [C_GLB_DATA_W-1:0] i_glb_dout,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic [C_GLB_DATA_W-1:0] o_m_data,
    output logic [C_GLB_KEEP_W-1:0] o_m_keep,
    output logic                    o_m_last
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_raddr_hold;
    logic [LEN_WIDTH-1:0]    r_rem;
    logic                    r_infl;
    logic [C_GLB_KEEP_W-1:0] r_infl_keep;
    logic                    r_infl_last;
    logic                    r_zero_done;

    logic                    w_idle;
    logic                    w_run;
    logic                    w_accept;
    logic                    w_accept_zero;
    logic                    w_rem_ge4;
    logic [C_GLB_KEEP_W-1:0] w_mask;
    logic [1:0]              w_occ;
    logic [2:0]              w_slots;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_pop;
    logic                    w_flush_done;

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [C_GLB_DATA_W-1:0] w_head_data;
    logic [C_GLB_KEEP_W-1:0] w_head_keep;
    logic                    w_head_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_state_nxt = ST_RUN;
            ST_RUN:   if (w_issue_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_done) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_idle = 1'b0;
        w_run  = 1'b0;
        o_busy = 1'b0;
        case (r_state)
            ST_IDLE:  w_idle = 1'b1;
            ST_RUN: begin
                w_run  = 1'b1;
                o_busy = 1'b1;
            end
            ST_FLUSH: o_busy = 1'b1;
            default:  w_idle = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    assign w_accept      = w_idle && i_start && (i_byte_len != '0);
    assign w_accept_zero = w_idle && i_start && (i_byte_len == '0);
    assign w_rem_ge4     = (r_rem >= LEN_WIDTH'(4));
    assign w_mask        = read_mask(w_rem_ge4, r_rem[1:0]);
    assign w_pop         = !w_fifo_empty && i_m_ready;

    // Occupancy is counted after this cycle's pop so a read can be issued
    // every cycle while the consumer keeps up; a beat issued now lands one
    // edge later, so the buffer cannot overflow.
    assign w_occ         = {w_fifo_full, !w_fifo_full && !w_fifo_empty};
    assign w_slots       = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_infl};
    assign w_issue       = w_run && (w_slots < 3'(BUF_DEPTH));
    assign w_issue_last  = w_issue && (r_rem <= LEN_WIDTH'(4));
    assign w_flush_done  = (r_state == ST_FLUSH) && w_pop && w_head_last;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_raddr_hold <= '0;
            r_rem        <= '0;
            r_infl       <= 1'b0;
            r_infl_keep  <= '0;
            r_infl_last  <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            r_zero_done <= w_accept_zero;
            r_infl      <= w_issue;
            if (w_issue) begin
                r_infl_keep <= w_mask;
                r_infl_last <= w_issue_last;
            end
            if (w_accept) begin
                r_addr <= i_base_addr;
                r_rem  <= i_byte_len;
            end else if (w_issue) begin
                r_addr       <= r_addr + ADDR_WIDTH'(4);
                r_rem        <= w_rem_ge4 ? (r_rem - LEN_WIDTH'(4)) : '0;
                r_raddr_hold <= r_addr;
            end
        end
    end

    // The GLB sees the current address only while reading; otherwise the
    // address of the most recent read is held.
    assign o_glb_re    = w_issue ? w_mask : C_MASK_NONE;
    assign o_glb_raddr = w_issue ? r_addr : r_raddr_hold;
    assign o_done      = r_zero_done || w_flush_done;

    // ------------------------------------------------------------------
    // Output buffer: the read issued last cycle is captured now
    // ------------------------------------------------------------------
    glb_stream_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_infl),
        .i_data  (i_glb_dout),
        .i_keep  (r_infl_keep),
        .i_last  (r_infl_last),
        .i_pop   (w_pop),
        .o_data  (w_head_data),
        .o_keep  (w_head_keep),
        .o_last  (w_head_last),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_m_valid = !w_fifo_empty;
    assign o_m_data  = w_head_data;
    assign o_m_keep  = w_head_keep;
    assign o_m_last  = w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_glb_read_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_glb_read_streamer
//  Purpose  : Self-checking bench for glb_read_streamer with a GLB memory
//             model and a read/beat scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_glb_read_streamer;

    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic [3:0]    glb_re;
    logic [AW-1:0] glb_raddr;
    logic [31:0]   glb_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic [3:0]    m_keep;
    logic          m_last;

    always #5 clk = ~clk;

    glb_read_streamer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_base_addr (base),
        .i_byte_len  (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_glb_re    (glb_re),
        .o_glb_raddr (glb_raddr),
        .i_glb_dout  (glb_dout),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_m_keep    (m_keep),
        .o_m_last    (m_last)
    );

    // Memory contents are a pure function of the word address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F1E_2D3C;
    endfunction

    // Synchronous-read GLB: data appears the cycle after a read.
    always @(posedge clk) begin
        if (glb_re != 4'b0000) glb_dout <= word_at(glb_raddr);
    end

    typedef struct { logic [31:0] addr; logic [3:0] re; } rd_t;
    typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        bit          rnd_ready;
        int          exp_beats;
        logic [3:0]  exp_last_keep;
    } vec_t;

    rd_t   exp_rds[$];
    beat_t exp_beats[$];

    int checks = 0;
    int fails  = 0;
    int beats_seen = 0;
    int reads_seen = 0;
    int done_cnt   = 0;
    logic [3:0] last_keep_seen = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        rd_t   r;
        beat_t b;
        if (!rst) begin
            if (done) done_cnt++;
            if (glb_re != 4'b0000) begin
                reads_seen++;
                if (exp_rds.size() == 0) begin
                    check("unexpected_read", {60'd0, glb_re}, 64'd0);
                end else begin
                    r = exp_rds.pop_front();
                    check("rd_addr", {32'd0, glb_raddr}, {32'd0, r.addr});
                    check("rd_mask", {60'd0, glb_re}, {60'd0, r.re});
                end
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                if (m_last) last_keep_seen = m_keep;
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", {63'd0, m_valid}, 64'd0);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_data", {32'd0, m_data}, {32'd0, b.data});
                    check("beat_keep", {60'd0, m_keep}, {60'd0, b.keep});
                    check("beat_last", {63'd0, m_last}, {63'd0, b.last});
                    if (b.last) check("done_on_last", {63'd0, done}, 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns in the cycle after it was sampled.
    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reference model of the transfer: one read and one beat per word.
    task automatic push_expected(input logic [31:0] b, input logic [15:0] l);
        logic [31:0] a;
        int          rem;
        logic [3:0]  k;
        a   = b;
        rem = int'(l);
        while (rem > 0) begin
            case (rem)
                1:       k = 4'b0001;
                2:       k = 4'b0011;
                3:       k = 4'b0111;
                default: k = 4'b1111;
            endcase
            exp_rds.push_back('{addr: a, re: k});
            exp_beats.push_back('{data: word_at(a), keep: k, last: (rem <= 4)});
            a   = a + 32'd4;
            rem = (rem >= 4) ? rem - 4 : 0;
        end
    endtask

    task automatic drain(input int max, input bit rnd);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || busy) && n < max) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("drain_in_time", {63'd0, (n < max)}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {63'd0, busy},    64'd0);
        check({tag, "_done"},   {63'd0, done},    64'd0);
        check({tag, "_re"},     {60'd0, glb_re},  64'd0);
        check({tag, "_raddr"},  {32'd0, glb_raddr}, 64'd0);
        check({tag, "_mvalid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_mkeep"},  {60'd0, m_keep},  64'd0);
        check({tag, "_mlast"},  {63'd0, m_last},  64'd0);
        check({tag, "_mdata"},  {32'd0, m_data},  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   b0, d0, r0, n;

        vecs[0] = '{base: 32'h0000_0100, len: 16'd8,  rnd_ready: 1'b0, exp_beats: 2, exp_last_keep: 4'b1111};
        vecs[1] = '{base: 32'h0000_0200, len: 16'd6,  rnd_ready: 1'b0, exp_beats: 2, exp_last_keep: 4'b0011};
        vecs[2] = '{base: 32'h0000_0300, len: 16'd1,  rnd_ready: 1'b1, exp_beats: 1, exp_last_keep: 4'b0001};
        vecs[3] = '{base: 32'h0000_0400, len: 16'd3,  rnd_ready: 1'b1, exp_beats: 1, exp_last_keep: 4'b0111};
        vecs[4] = '{base: 32'hFFFF_FFFC, len: 16'd9,  rnd_ready: 1'b0, exp_beats: 3, exp_last_keep: 4'b0001};
        vecs[5] = '{base: 32'h0000_0500, len: 16'd17, rnd_ready: 1'b1, exp_beats: 5, exp_last_keep: 4'b0001};
        vecs[6] = '{base: 32'h0000_0600, len: 16'd4,  rnd_ready: 1'b0, exp_beats: 1, exp_last_keep: 4'b1111};
        vecs[7] = '{base: 32'h0000_0640, len: 16'd7,  rnd_ready: 1'b1, exp_beats: 2, exp_last_keep: 4'b0111};

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Latency and cycle-exact behaviour, len=8 from 0x100
        m_ready = 1'b1;
        d0 = done_cnt;
        push_expected(32'h100, 16'd8);
        pulse_start(32'h100, 16'd8);
        check("lat_c1_re",    {60'd0, glb_re},    64'hF);
        check("lat_c1_addr",  {32'd0, glb_raddr}, 64'h100);
        check("lat_c1_busy",  {63'd0, busy},      64'd1);
        check("lat_c1_valid", {63'd0, m_valid},   64'd0);
        tick();
        check("lat_c2_re",    {60'd0, glb_re},    64'hF);
        check("lat_c2_addr",  {32'd0, glb_raddr}, 64'h104);
        check("lat_c2_valid", {63'd0, m_valid},   64'd0);
        tick();
        check("lat_c3_re",    {60'd0, glb_re},    64'd0);
        check("lat_c3_hold",  {32'd0, glb_raddr}, 64'h104);
        check("lat_c3_valid", {63'd0, m_valid},   64'd1);
        check("lat_c3_data",  {32'd0, m_data},    {32'd0, word_at(32'h100)});
        check("lat_c3_last",  {63'd0, m_last},    64'd0);
        check("lat_c3_done",  {63'd0, done},      64'd0);
        tick();
        check("lat_c4_last",  {63'd0, m_last},    64'd1);
        check("lat_c4_done",  {63'd0, done},      64'd1);
        check("lat_c4_busy",  {63'd0, busy},      64'd1);
        tick();
        check("lat_c5_busy",  {63'd0, busy},      64'd0);
        check("lat_c5_done",  {63'd0, done},      64'd0);
        check("lat_c5_valid", {63'd0, m_valid},   64'd0);
        check("lat_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            b0 = beats_seen;
            d0 = done_cnt;
            push_expected(vecs[i].base, vecs[i].len);
            m_ready = vecs[i].rnd_ready ? 1'b0 : 1'b1;
            pulse_start(vecs[i].base, vecs[i].len);
            drain(300, vecs[i].rnd_ready);
            tick();
            check($sformatf("vec%0d_beats", i), 64'(beats_seen - b0), 64'(vecs[i].exp_beats));
            check($sformatf("vec%0d_lastkeep", i), {60'd0, last_keep_seen}, {60'd0, vecs[i].exp_last_keep});
            check($sformatf("vec%0d_done", i), 64'(done_cnt - d0), 64'd1);
            check($sformatf("vec%0d_rds_left", i), 64'(exp_rds.size()), 64'd0);
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd0);
        end

        // Zero-length command
        d0 = done_cnt;
        pulse_start(32'h123, 16'd0);
        check("zero_done", {63'd0, done},   64'd1);
        check("zero_busy", {63'd0, busy},   64'd0);
        check("zero_re",   {60'd0, glb_re}, 64'd0);
        tick();
        check("zero_done_clr", {63'd0, done}, 64'd0);
        check("zero_busy_c2",  {63'd0, busy}, 64'd0);
        tick();
        check("zero_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Back-pressure: 10 stalled cycles, exactly two reads outstanding
        m_ready = 1'b0;
        r0 = reads_seen;
        d0 = done_cnt;
        push_expected(32'h700, 16'd16);
        pulse_start(32'h700, 16'd16);
        repeat (9) tick();
        check("stall_reads", 64'(reads_seen - r0), 64'd2);
        check("stall_valid", {63'd0, m_valid}, 64'd1);
        check("stall_head",  {32'd0, m_data},  {32'd0, word_at(32'h700)});
        check("stall_keep",  {60'd0, m_keep},  64'hF);
        drain(300, 1'b0);
        tick();
        check("stall_reads_total", 64'(reads_seen - r0), 64'd4);
        check("stall_done", 64'(done_cnt - d0), 64'd1);

        // Start while busy is ignored
        m_ready = 1'b1;
        b0 = beats_seen;
        d0 = done_cnt;
        push_expected(32'h800, 16'd12);
        pulse_start(32'h800, 16'd12);
        tick();
        pulse_start(32'h900, 16'd20);
        drain(300, 1'b0);
        tick();
        check("busy_start_beats", 64'(beats_seen - b0), 64'd3);
        check("busy_start_done",  64'(done_cnt - d0), 64'd1);
        check("busy_start_rds",   64'(exp_rds.size()), 64'd0);

        // Reset mid-transfer after the second beat
        m_ready = 1'b1;
        b0 = beats_seen;
        d0 = done_cnt;
        push_expected(32'hA00, 16'd16);
        pulse_start(32'hA00, 16'd16);
        n = 0;
        while (beats_seen < b0 + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait", {63'd0, (n < 50)}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_rds.delete();
        exp_beats.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("postrst_valid", {63'd0, m_valid}, 64'd0);
        check("postrst_busy",  {63'd0, busy},    64'd0);
        check("postrst_nodone", 64'(done_cnt - d0), 64'd0);

        // Clean transfer after reset
        b0 = beats_seen;
        d0 = done_cnt;
        push_expected(32'hB00, 16'd10);
        pulse_start(32'hB00, 16'd10);
        drain(300, 1'b0);
        tick();
        check("after_rst_beats", 64'(beats_seen - b0), 64'd3);
        check("after_rst_done",  64'(done_cnt - d0), 64'd1);
        check("final_beats_left", 64'(exp_beats.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
